// File: rtl/decode_unit_pkg.sv
// Types and constants shared by the pipeline stages around instruction decode.
package decode_unit_pkg;

  localparam int DEC_XLEN     = 32;
  localparam int DEC_REG_BITS = 4;

  typedef enum logic [3:0] {
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
    OP_STORE, OP_ALU_IMM, OP_ALU_REG, OP_FENCE, OP_SYSTEM, OP_ILLEGAL
  } op_class_t;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_ALU_IMM = 7'b0010011;
  localparam logic [6:0] OPC_ALU_REG = 7'b0110011;
  localparam logic [6:0] OPC_FENCE   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  // funct7 encodings accepted by the base integer ALU.
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  typedef struct packed {
    op_class_t                 op;
    logic [2:0]                funct3;
    logic                      alt;
    logic [DEC_REG_BITS-1:0]   rd;
    logic [DEC_REG_BITS-1:0]   rs1;
    logic [DEC_REG_BITS-1:0]   rs2;
    logic [DEC_XLEN-1:0]       imm;
    logic                      illegal;
  } decoded_instr_t;

endpackage

// File: rtl/decode_unit_instr_decoder.sv
// Purely combinational RV32E decoder: raw instruction word -> decoded_instr_t.
module instr_decoder
  import decode_unit_pkg::*;
(
  input  logic [31:0]    instr,
  output decoded_instr_t dec
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  op_class_t   op;
  logic        use_rd, use_rs1, use_rs2;
  logic        bad;
  logic [31:0] imm;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Classify the opcode, pick the immediate format and apply the legality rules.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and give every output a default
    // first, so nothing holds its value between evaluations and no latch is inferred.
    op      = OP_ILLEGAL;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    imm     = '0;
    bad     = 1'b0;
    case (opcode)
      OPC_LUI:     begin op = OP_LUI;     use_rd = 1'b1; imm = imm_u; end
      OPC_AUIPC:   begin op = OP_AUIPC;   use_rd = 1'b1; imm = imm_u; end
      OPC_JAL:     begin op = OP_JAL;     use_rd = 1'b1; imm = imm_j; end
      OPC_JALR: begin
        op = OP_JALR; use_rd = 1'b1; use_rs1 = 1'b1; imm = imm_i;
        bad = (funct3 != 3'd0);
      end
      OPC_BRANCH: begin
        op = OP_BRANCH; use_rs1 = 1'b1; use_rs2 = 1'b1; imm = imm_b;
        bad = (funct3 == 3'd2) || (funct3 == 3'd3);
      end
      OPC_LOAD: begin
        op = OP_LOAD; use_rd = 1'b1; use_rs1 = 1'b1; imm = imm_i;
        bad = (funct3 == 3'd3) || (funct3 >= 3'd6);
      end
      OPC_STORE: begin
        op = OP_STORE; use_rs1 = 1'b1; use_rs2 = 1'b1; imm = imm_s;
        bad = (funct3 > 3'd2);
      end
      OPC_ALU_IMM: begin
        op = OP_ALU_IMM; use_rd = 1'b1; use_rs1 = 1'b1; imm = imm_i;
        // Shift-immediates reuse the upper bits as funct7; only SRAI may set bit 30.
        if (funct3 == 3'd1)      bad = (funct7 != F7_BASE);
        else if (funct3 == 3'd5) bad = (funct7 != F7_BASE) && (funct7 != F7_ALT);
      end
      OPC_ALU_REG: begin
        op = OP_ALU_REG; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        bad = !((funct7 == F7_BASE) ||
                ((funct7 == F7_ALT) && ((funct3 == 3'd0) || (funct3 == 3'd5))));
      end
      OPC_FENCE:   begin op = OP_FENCE;  imm = imm_i; end
      OPC_SYSTEM: begin
        op = OP_SYSTEM; imm = imm_i;
        bad = (instr != INSTR_ECALL) && (instr != INSTR_EBREAK);
      end
      default:     bad = 1'b1;
    endcase

    // Register bit 4 addresses x16..x31, which RV32E does not have.
    bad = bad || (instr[1:0] != 2'b11) || (use_rd && instr[11]) ||
          (use_rs1 && instr[19]) || (use_rs2 && instr[24]);

    dec.op      = bad ? OP_ILLEGAL : op;
    dec.funct3  = funct3;
    dec.alt     = instr[30];
    dec.rd      = (!bad && use_rd)  ? instr[10:7]  : '0;
    dec.rs1     = (!bad && use_rs1) ? instr[18:15] : '0;
    dec.rs2     = (!bad && use_rs2) ? instr[23:20] : '0;
    dec.imm     = bad ? '0 : imm;
    dec.illegal = bad;
  end

endmodule

// File: rtl/decode_unit.sv
// Decode stage: one-entry registered output buffer around instr_decoder, with flush.
module decode_unit
  import decode_unit_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REG_BITS = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_address,
  input  logic [31:0]         in_instruction,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_address,
  output op_class_t           out_op,
  output logic [2:0]          out_funct3,
  output logic                out_alt,
  output logic [REG_BITS-1:0] out_rd,
  output logic [REG_BITS-1:0] out_rs1,
  output logic [REG_BITS-1:0] out_rs2,
  output logic [XLEN-1:0]     out_imm,
  output logic                out_illegal
);

  decoded_instr_t dec;
  logic           accept;

  instr_decoder u_decoder (
    .instr (in_instruction),
    .dec   (dec)
  );

  // Looking at out_ready lets a new beat replace a departing one with no bubble.
  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Occupancy of the output buffer; flush wins over every other event.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values regardless of block ordering.
    if (reset)          out_valid <= 1'b0;
    else if (flush)     out_valid <= 1'b0;
    else if (accept)    out_valid <= 1'b1;
    else if (out_ready) out_valid <= 1'b0;
  end

  // Capture the decoded beat on accept; otherwise hold it stable for execute.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: these data registers are reset so execute never sees X after reset;
    // they are plain flops, not a memory, so the reset costs nothing unusual.
    if (reset) begin
      out_address <= '0;
      out_op      <= OP_LUI;
      out_funct3  <= '0;
      out_alt     <= 1'b0;
      out_rd      <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_imm     <= '0;
      out_illegal <= 1'b0;
    end else if (accept) begin
      out_address <= in_address;
      out_op      <= dec.op;
      out_funct3  <= dec.funct3;
      out_alt     <= dec.alt;
      out_rd      <= dec.rd;
      out_rs1     <= dec.rs1;
      out_rs2     <= dec.rs2;
      out_imm     <= dec.imm;
      out_illegal <= dec.illegal;
    end
  end

endmodule

// File: doc/decode_unit.md
Name: decode_unit

Overview:
- RV32E instruction decode stage, directly downstream of the fetch stage.
- Consumes {address, instruction} beats over a valid/ready handshake and decodes each into register indices, a sign-extended immediate, an operation class and an illegal flag.
- Presents the result to execute/control through a registered valid/ready output, with one cycle of latency.
- A flush from the control unit discards the held beat and any beat arriving in the same cycle.

Parameters:
- XLEN, 32, datapath and address width; only 32 is supported.
- REG_BITS, 4, register index width; RV32E has 16 registers, so only x0..x15 exist.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  from control unit; discard the held and the incoming beat.
- in_valid  in  1  fetch offers a beat.
- in_ready  out  1  decode accepts the beat; combinational.
- in_address  in  XLEN  PC of the instruction.
- in_instruction  in  32  raw instruction word.
- out_valid  out  1  decoded beat held for execute.
- out_ready  in  1  execute consumes the beat.
- out_address  out  XLEN  registered PC.
- out_op  out  op_class_t  operation class.
- out_funct3  out  3  instruction[14:12].
- out_alt  out  1  instruction[30]; selects SUB/SRA for the ALU.
- out_rd  out  REG_BITS  destination register; 0 if the class has no rd.
- out_rs1  out  REG_BITS  source 1; 0 if unused.
- out_rs2  out  REG_BITS  source 2; 0 if unused.
- out_imm  out  XLEN  sign-extended immediate; 0 for R-type.
- out_illegal  out  1  instruction is illegal on RV32E.

Behaviour:
- Reset: asynchronous, active-high. All out_* registers go to 0 and out_valid to 0. in_ready is 1 once reset is released. Reset in the middle of a stall drops the held beat.
- Handshake:
  - in_ready = !flush && (!out_valid || out_ready).
  - A beat transfers in when in_valid && in_ready.
  - A beat leaves when out_valid && out_ready.
  - While out_valid && !out_ready, every out_* register holds stable.
- Latency: 1 cycle. A beat accepted in cycle N is visible with out_valid=1 in cycle N+1.
- Throughput: one beat per cycle with no bubbles, because in_ready looks at out_ready.
- Flush has priority over everything:
  - next cycle out_valid=0;
  - the input beat in the same cycle is not accepted (in_ready=0);
  - the data registers may keep stale values.
- Simultaneous out_ready and in_valid: the held beat is consumed and the new beat loaded in the same edge.
- Decode is combinational on in_instruction and captured on accept. There is no state machine beyond out_valid.
- Opcode classes (instruction[6:0]):
  - 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 1100011 BRANCH;
  - 0000011 LOAD, 0100011 STORE, 0010011 ALU_IMM, 0110011 ALU_REG;
  - 0001111 FENCE, 1110011 SYSTEM;
  - any other opcode is ILLEGAL.
- Immediates:
  - I-type: inst[31:20] sign-extended.
  - S-type: {inst[31:25], inst[11:7]}.
  - B-type: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U-type: {inst[31:12], 12'b0}.
  - J-type: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - All sign-extended to XLEN.
- Illegal if any of the following (then out_op=OP_ILLEGAL, out_illegal=1, beat still passed with out_valid=1):
  - inst[1:0] != 11;
  - bit 4 set in any register field that the class uses (register above x15);
  - JALR with funct3 != 0;
  - BRANCH with funct3 of 2 or 3;
  - LOAD with funct3 of 3, 6 or 7;
  - STORE with funct3 > 2;
  - ALU_REG with funct7 not 0000000, or funct7 = 0100000 on a funct3 other than 0 or 5;
  - ALU_IMM shifts (funct3 1 or 5) with inst[31:25] not 0000000, or 0100000 on funct3=5;
  - SYSTEM other than ECALL (0x00000073) or EBREAK (0x00100073).
- Illegal beats carry the original address. out_rd, out_rs1 and out_rs2 are 0 on illegal beats.

Decomposition:
- Shared package (with the other pipeline stages' types): op_class_t enum (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_ALU_IMM, OP_ALU_REG, OP_FENCE, OP_SYSTEM, OP_ILLEGAL), the opcode constants, and the decoded_instr_t struct.
- One combinational sub-module, instr_decoder, maps the 32-bit word to decoded_instr_t. decode_unit wraps it with the handshake register and flush.

Test Plan:
- addi x1,x0,5 (0x00500093) at address 0x100, out_ready=1 -> next cycle: out_valid=1, OP_ALU_IMM, rd=1, rs1=0, imm=5, funct3=0, address=0x100, illegal=0.
- sub x3,x1,x2 (0x402081B3), then beq x0,x0,-4 (0xFE000EE3) back-to-back:
  - first -> OP_ALU_REG, alt=1, rd=3, rs1=1, rs2=2;
  - second -> OP_BRANCH, imm=0xFFFFFFFC;
  - two beats in two cycles, no bubble.
- add x16,x0,x0 (0x00000833) -> out_valid=1, OP_ILLEGAL, illegal=1, rd=0. Also 0x00000000 -> illegal=1.
- lui x5,0x12345 (0x123452B7) held with out_ready=0 for 3 cycles:
  - in_ready=0 and outputs stable, with imm=0x12345000 and rd=5;
  - a pending in_valid beat is not lost and appears the cycle after out_ready=1.
- flush asserted while out_valid=1 and in_valid=1 -> in_ready=0 that cycle; next cycle out_valid=0; the flushed input never appears on the output.
- reset pulsed mid-stall -> out_valid=0 immediately (asynchronous); after release, in_ready=1 and the first new beat decodes normally.
